wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Register-file write-port arbiter (LSU priority, ALU starvation
//            guard) with a registered write port and decode RAW hazard flag.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    output logic            hazard,
    output logic            arb_state
);

    localparam logic [0:0]       c_normal    = 1'b0;
    localparam logic [0:0]       c_force_alu = 1'b1;
    localparam logic [CNT_W-1:0] c_limit     = CNT_W'(STARVE_LIMIT);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_we;
    logic [4:0]       r_waddr;
    logic [XLEN-1:0]  r_wdata;

    logic             w_force;
    logic             w_alu_gnt;
    logic             w_lsu_gnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [4:0]       w_gnt_rd;
    logic [XLEN-1:0]  w_gnt_data;
    logic             w_haz_rs1;
    logic             w_haz_rs2;

    assign w_force   = (r_state == c_force_alu);
    assign w_alu_gnt = !RST && alu_valid && (!lsu_valid || w_force);
    assign w_lsu_gnt = !RST && lsu_valid && !w_alu_gnt;
    assign w_cnt_inc = r_starve_cnt + CNT_W'(1);

    assign w_gnt_rd   = w_alu_gnt ? alu_rd   : lsu_rd;
    assign w_gnt_data = w_alu_gnt ? alu_data : lsu_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= c_normal;
            r_starve_cnt <= '0;
        end else if (alu_valid && !w_alu_gnt) begin
            r_starve_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_limit) begin
                r_state <= c_force_alu;
            end
        end else begin
            r_starve_cnt <= '0;
            if (w_alu_gnt) begin
                r_state <= c_normal;
            end
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if ((w_alu_gnt || w_lsu_gnt) && (w_gnt_rd != 5'd0)) begin
            r_we    <= 1'b1;
            r_waddr <= w_gnt_rd;
            r_wdata <= w_gnt_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // The rf_waddr term covers a write landing in the same cycle decode reads.
    assign w_haz_rs1 = (dec_rs1 != 5'd0) &&
                       ((alu_valid && (dec_rs1 == alu_rd)) ||
                        (lsu_valid && (dec_rs1 == lsu_rd)) ||
                        (r_we      && (dec_rs1 == r_waddr)));
    assign w_haz_rs2 = (dec_rs2 != 5'd0) &&
                       ((alu_valid && (dec_rs2 == alu_rd)) ||
                        (lsu_valid && (dec_rs2 == lsu_rd)) ||
                        (r_we      && (dec_rs2 == r_waddr)));

    assign alu_ready = w_alu_gnt;
    assign lsu_ready = w_lsu_gnt;
    assign hazard    = w_haz_rs1 || w_haz_rs2;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign arb_state = r_state[0];

endmodule
`default_nettype wire
